mem_wb_skid_reg: RTL and testbench
==================================

# mem_wb_skid_reg

Parametrised MEM→WB pipeline boundary register with a valid/ready handshake, a two-entry skid buffer, a flush input and a retired-transfer counter. It sits between the memory stage and the writeback stage. A writeback-side stall (out_ready low) is absorbed without losing the instruction already in flight. A pipeline flush turns everything held into bubbles.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and memory read data
- REG_W, 5, width of destination register index
- INSTR_W, 32, width of carried instruction word
- CNT_W, 16, width of retired-transfer counter

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all held entries this cycle
- in_valid  in  1  MEM-side entry valid
- in_ready  out  1  buffer can accept an entry this cycle
- in_regwrite, in_memtoreg  in  1 each  MEM control bits
- in_aluout, in_readdata  in  DATA_W each  MEM-stage datapath values
- in_writereg  in  REG_W  destination register
- in_instr  in  INSTR_W  instruction word, for trace
- out_valid  out  1  WB-side entry valid
- out_ready  in  1  WB stage consumes entry this cycle
- out_regwrite, out_memtoreg  out  1 each  control bits, forced 0 when out_valid=0
- out_aluout, out_readdata  out  DATA_W each  held datapath values
- out_writereg  out  REG_W  held destination
- out_instr  out  INSTR_W  held instruction
- out_result  out  DATA_W  out_memtoreg ? out_readdata : out_aluout (combinational from main entry)
- occupancy  out  2  entries held, 0..2
- retired_count  out  CNT_W  count of completed output transfers

## Operation
- Storage: main entry (drives outputs) and skid entry. Each entry holds regwrite, memtoreg, aluout, readdata, writereg, instr.
- States: EMPTY (occupancy 0), ONE (main full), TWO (main and skid full).
- in_ready = (state != TWO). It is derived only from state flops, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- EMPTY: input transfer → main ← input, go to ONE. Otherwise stay.
- ONE:
  - input only → skid ← input, go to TWO.
  - output only → go to EMPTY.
  - both → main ← input, stay ONE.
  - neither → stay.
- TWO: output transfer → main ← skid, go to ONE. Otherwise stay. No input accepted (in_ready=0).
- Order is strictly FIFO. An entry is never dropped or duplicated except by flush or reset.
- flush=1: next state EMPTY, and main and skid payloads are cleared to 0.
  - An input offered in the flush cycle is discarded, even if in_ready=1.
  - An output transfer completing in the flush cycle counts as completed: the WB stage took it.
- retired_count increments by 1 on each output transfer and wraps modulo 2^CNT_W.
- reset=1: state EMPTY, all payload bits 0, retired_count 0. reset dominates flush and all transfers.
- In EMPTY, out_regwrite and out_memtoreg read 0. Bubbles therefore never write the register file.

## Timing
- Latency in→out is 1 cycle: an entry accepted at edge N is visible on the outputs after edge N.
- Throughput is 1 entry/cycle while out_ready=1.
- in_ready falls in the cycle after the second entry is captured with no output transfer. It rises in the cycle after the skid entry is promoted.
- Reset values, in the cycle after a reset edge:
  - out_valid=0, in_ready=1, occupancy=0, retired_count=0.
  - All out_* data outputs 0, and out_result 0.
- flush takes effect at the same edge: the cycle after a flush has out_valid=0 and in_ready=1.
- Reset asserted mid-stall (state TWO) empties the buffer at that edge. Held entries are lost and not counted.

## Test plan
- Stream: reset, then 8 entries with instr=0x1000+i and aluout=i, out_ready=1 throughout. Required: out_instr 0x1000..0x1007 in order, one per cycle, each one cycle after its input; retired_count=8.
- Backpressure: out_ready=0 while offering entries with instr A=0xA, B=0xB, C=0xC. Required: A and B accepted, occupancy=2, in_ready=0, C held at input. Then out_ready=1: required outputs A, B, C in order with no loss or duplication.
- Flush in TWO: occupancy=2, flush=1 with a new in_valid entry and out_ready=0. Required next cycle: out_valid=0, occupancy=0, out_regwrite=0, all data outputs 0, retired_count unchanged.
- Flush with simultaneous output transfer in state ONE, out_ready=1. Required: retired_count +1, state EMPTY.
- out_result mux: entry with aluout=0x11, readdata=0x22. With memtoreg=1, out_result=0x22; with memtoreg=0, out_result=0x11.
- Counter wrap with CNT_W=4: 17 output transfers. Required: retired_count=1. Reset asserted in state TWO → occupancy=0, retired_count=0 the next cycle.

Source files
------------

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB boundary register: valid/ready handshake with a two-entry skid buffer,
// flush-to-bubble and a retired-transfer counter.
module mem_wb_skid_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_regwrite,
    input  logic               in_memtoreg,
    input  logic [DATA_W-1:0]  in_aluout,
    input  logic [DATA_W-1:0]  in_readdata,
    input  logic [REG_W-1:0]   in_writereg,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_regwrite,
    output logic               out_memtoreg,
    output logic [DATA_W-1:0]  out_aluout,
    output logic [DATA_W-1:0]  out_readdata,
    output logic [REG_W-1:0]   out_writereg,
    output logic [INSTR_W-1:0] out_instr,
    output logic [DATA_W-1:0]  out_result,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   retired_count
);

    typedef struct packed {
        logic               regwrite;
        logic               memtoreg;
        logic [DATA_W-1:0]  aluout;
        logic [DATA_W-1:0]  readdata;
        logic [REG_W-1:0]   writereg;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    // Encoding equals the number of entries held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    entry_t in_ent_c;
    logic   in_xfer_c;
    logic   out_xfer_c;

    assign in_ent_c.regwrite = in_regwrite;
    assign in_ent_c.memtoreg = in_memtoreg;
    assign in_ent_c.aluout   = in_aluout;
    assign in_ent_c.readdata = in_readdata;
    assign in_ent_c.writereg = in_writereg;
    assign in_ent_c.instr    = in_instr;

    assign in_ready   = (state_q != TWO);
    assign out_valid  = (state_q != EMPTY);
    assign in_xfer_c  = in_valid & in_ready;
    assign out_xfer_c = out_valid & out_ready;

    // Next-state and payload movement; flush overrides everything but the count.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q + CNT_W'(out_xfer_c);
        case (state_q)
            EMPTY: begin
                if (in_xfer_c) begin
                    main_d  = in_ent_c;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({in_xfer_c, out_xfer_c})
                    2'b10: begin
                        skid_d  = in_ent_c;
                        state_d = TWO;
                    end
                    2'b01:   state_d = EMPTY;
                    2'b11:   main_d  = in_ent_c;
                    default: ;
                endcase
            end
            TWO: begin
                if (out_xfer_c) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Control bits gated so a bubble can never write the register file.
    assign out_regwrite  = main_q.regwrite & out_valid;
    assign out_memtoreg  = main_q.memtoreg & out_valid;
    assign out_aluout    = main_q.aluout;
    assign out_readdata  = main_q.readdata;
    assign out_writereg  = main_q.writereg;
    assign out_instr     = main_q.instr;
    assign out_result    = out_memtoreg ? main_q.readdata : main_q.aluout;
    assign occupancy     = 2'(state_q);
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Bench for mem_wb_skid_reg: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_wb_skid_reg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 4;

    logic               clk = 1'b0;
    logic               reset, flush, in_valid, in_ready;
    logic               in_regwrite, in_memtoreg;
    logic [DATA_W-1:0]  in_aluout, in_readdata;
    logic [REG_W-1:0]   in_writereg;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid, out_ready, out_regwrite, out_memtoreg;
    logic [DATA_W-1:0]  out_aluout, out_readdata, out_result;
    logic [REG_W-1:0]   out_writereg;
    logic [INSTR_W-1:0] out_instr;
    logic [1:0]         occupancy;
    logic [CNT_W-1:0]   retired_count;

    always #5 clk = ~clk;

    mem_wb_skid_reg #(
        .DATA_W(DATA_W), .REG_W(REG_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_aluout(in_aluout), .in_readdata(in_readdata),
        .in_writereg(in_writereg), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg),
        .out_aluout(out_aluout), .out_readdata(out_readdata),
        .out_writereg(out_writereg), .out_instr(out_instr),
        .out_result(out_result), .occupancy(occupancy),
        .retired_count(retired_count)
    );

    typedef struct {
        logic               rw;
        logic               mtr;
        logic [DATA_W-1:0]  alu;
        logic [DATA_W-1:0]  rd;
        logic [REG_W-1:0]   wr;
        logic [INSTR_W-1:0] instr;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_cnt  = 0;
    bit          m_zero = 1'b1;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most two entries, updated at each rising edge.
    always @(posedge clk) begin : model
        bit   ox, ix;
        ent_t e, popped;
        ox = (mq.size() > 0) && (out_ready === 1'b1);
        ix = (in_valid === 1'b1) && (mq.size() < 2);
        e.rw = in_regwrite; e.mtr = in_memtoreg; e.alu = in_aluout;
        e.rd = in_readdata; e.wr = in_writereg; e.instr = in_instr;
        if (reset) begin
            mq.delete();
            m_cnt  = 0;
            m_zero = 1'b1;
        end else if (flush) begin
            if (ox) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            mq.delete();
            m_zero = 1'b1;
        end else begin
            if (ox) begin
                popped = mq.pop_front();
                m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            end
            if (ix) begin
                mq.push_back(e);
                m_zero = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        ent_t h;
        bit   v;
        if (chk_en) begin
            v = (mq.size() > 0);
            check("out_valid", 64'(out_valid), 64'(v));
            check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
            check("occupancy", 64'(occupancy), 64'(mq.size()));
            check("retired_count", 64'(retired_count), 64'(m_cnt));
            if (v) begin
                h = mq[0];
                check("out_regwrite", 64'(out_regwrite), 64'(h.rw));
                check("out_memtoreg", 64'(out_memtoreg), 64'(h.mtr));
                check("out_aluout", 64'(out_aluout), 64'(h.alu));
                check("out_readdata", 64'(out_readdata), 64'(h.rd));
                check("out_writereg", 64'(out_writereg), 64'(h.wr));
                check("out_instr", 64'(out_instr), 64'(h.instr));
                check("out_result", 64'(out_result), 64'(h.mtr ? h.rd : h.alu));
            end else begin
                check("bubble_regwrite", 64'(out_regwrite), 64'd0);
                check("bubble_memtoreg", 64'(out_memtoreg), 64'd0);
                if (m_zero) begin
                    check("cleared_aluout", 64'(out_aluout), 64'd0);
                    check("cleared_readdata", 64'(out_readdata), 64'd0);
                    check("cleared_instr", 64'(out_instr), 64'd0);
                    check("cleared_result", 64'(out_result), 64'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input logic [INSTR_W-1:0] ins, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] rd, input bit mtr, input bit rw, input bit ordy);
        in_valid    = v;
        in_instr    = ins;
        in_aluout   = alu;
        in_readdata = rd;
        in_memtoreg = mtr;
        in_regwrite = rw;
        in_writereg = ins[REG_W-1:0];
        out_ready   = ordy;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drv(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_retired", 64'(retired_count), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, INSTR_W'(32'h1000 + i), DATA_W'(i), '0, 1'b0, 1'b1, 1'b1);
            tick();
            check("stream_instr", 64'(out_instr), 64'(32'h1000 + i));
        end
        drv(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        check("stream_retired", 64'(retired_count), 64'd8);

        // Backpressure: A, B captured, C waits at the input
        drv(1'b1, 32'hA, 32'h1, '0, 1'b0, 1'b1, 1'b0);
        tick();
        drv(1'b1, 32'hB, 32'h2, '0, 1'b0, 1'b1, 1'b0);
        tick();
        check("bp_occupancy", 64'(occupancy), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        drv(1'b1, 32'hC, 32'h3, '0, 1'b0, 1'b1, 1'b0);
        tick();
        check("bp_hold_A", 64'(out_instr), 64'hA);
        out_ready = 1'b1;
        tick();
        check("bp_out_B", 64'(out_instr), 64'hB);
        tick();
        check("bp_out_C", 64'(out_instr), 64'hC);
        in_valid = 1'b0;
        tick();
        check("bp_drained", 64'(out_valid), 64'd0);
        check("bp_retired", 64'(retired_count), 64'd11);

        // Flush while full, with a new offer and no output transfer
        drv(1'b1, 32'hD, 32'h4, '0, 1'b0, 1'b1, 1'b0);
        tick();
        drv(1'b1, 32'hE, 32'h5, '0, 1'b0, 1'b1, 1'b0);
        tick();
        check("fl_full", 64'(occupancy), 64'd2);
        drv(1'b1, 32'hF, 32'h6, '0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_occupancy", 64'(occupancy), 64'd0);
        check("fl_regwrite", 64'(out_regwrite), 64'd0);
        check("fl_aluout", 64'(out_aluout), 64'd0);
        check("fl_instr", 64'(out_instr), 64'd0);
        check("fl_retired", 64'(retired_count), 64'd11);

        // Flush in ONE while the WB stage takes the entry
        drv(1'b1, 32'h77, 32'h7, '0, 1'b0, 1'b1, 1'b0);
        tick();
        drv(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flx_retired", 64'(retired_count), 64'd12);
        check("flx_occupancy", 64'(occupancy), 64'd0);

        // Result mux
        drv(1'b1, 32'h50, 32'h11, 32'h22, 1'b1, 1'b1, 1'b0);
        tick();
        check("mux_readdata", 64'(out_result), 64'h22);
        drv(1'b1, 32'h51, 32'h11, 32'h22, 1'b0, 1'b1, 1'b1);
        tick();
        check("mux_aluout", 64'(out_result), 64'h11);
        in_valid = 1'b0;
        tick();

        // Counter wrap: 17 transfers modulo 16
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drv(1'b1, INSTR_W'(32'h2000 + i), DATA_W'(i), '0, 1'b0, 1'b1, 1'b1);
            tick();
        end
        drv(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        check("wrap_retired", 64'(retired_count), 64'd1);

        // Reset mid-stall
        drv(1'b1, 32'h31, 32'h1, '0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        check("rs_full", 64'(occupancy), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rs_occupancy", 64'(occupancy), 64'd0);
        check("rs_retired", 64'(retired_count), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom % 128) == 0;
            flush = ($urandom % 32) == 0;
            drv(($urandom % 4) != 0, $urandom, $urandom, $urandom,
                1'($urandom), 1'($urandom), ($urandom % 3) != 0);
            tick();
        end
        reset = 1'b0;
        flush = 1'b0;
        drv(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
